// File: rtl/gpu_console_writer.sv
// Console front-end for the graphics card: turns an ASCII byte stream and colour commands
// into VRAM character writes and card instructions, tracking an 80x30 text cursor.
module gpu_console_writer #(
  parameter int COLS            = 80,
  parameter int ROWS            = 30,
  parameter int STROBE_CYCLES   = 4,
  parameter int CLEAR_LINE_WAIT = 128,
  parameter int CLEAR_SCR_WAIT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        color_valid,
  input  logic        color_sel,
  input  logic [7:0]  color_value,
  output logic [15:0] cpu_write_address,
  output logic [7:0]  cpu_write_data,
  output logic [15:0] io_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is only offered in IDLE with no colour command competing for the bus.
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_INSTR, S_WAIT} state_t;

  localparam int CW = $clog2(CLEAR_SCR_WAIT + 2);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  // WAIT lengths include the mandatory idle bus cycle that follows every strobe.
  localparam logic [CW-1:0] GAP_ONLY    = CW'(1);
  localparam logic [CW-1:0] LINE_GAP    = CW'(CLEAR_LINE_WAIT + 1);
  localparam logic [CW-1:0] SCR_GAP     = CW'(CLEAR_SCR_WAIT + 1);
  localparam logic [4:0]    ROW_LAST    = 5'(ROWS - 1);
  localparam logic [6:0]    COL_LAST    = 7'(COLS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_wait_len;
  logic            r_pend_clr;
  logic [4:0]      r_row;
  logic [6:0]      r_col;
  logic [4:0]      r_crow;
  logic [6:0]      r_ccol;
  logic [4:0]      r_wrow;
  logic [6:0]      r_wcol;
  logic [7:0]      r_wdata;
  logic [15:0]     r_instr;
  logic [15:0]     r_iaddr;
  logic            w_printable;
  logic            w_accept_byte;
  logic [4:0]      w_row_inc;

  assign w_printable   = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_accept_byte = in_valid && in_ready;
  assign w_row_inc     = (r_row == ROW_LAST) ? 5'd0 : r_row + 5'd1;
  assign cursor_row    = r_crow;
  assign cursor_col    = r_ccol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (color_valid) w_next = S_INSTR;
        else if (in_valid) begin
          if (w_printable || (in_data == 8'h08 && r_col != 7'd0)) w_next = S_WRITE;
          else if (in_data == 8'h0A || in_data == 8'h0C)         w_next = S_INSTR;
        end
      end
      S_WRITE, S_INSTR: if (r_cnt == STROBE_LAST) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == r_wait_len - 1'b1) w_next = r_pend_clr ? S_INSTR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_write_address = 16'h8000;
    cpu_write_data    = 8'h00;
    io_data           = 16'h0000;
    case (r_state)
      S_WRITE: begin
        cpu_write_address = {1'b0, 3'b000, r_wrow, r_wcol};
        cpu_write_data    = r_wdata;
      end
      S_INSTR: begin
        cpu_write_address = r_iaddr;
        io_data           = r_instr;
      end
      default: ;
    endcase
    in_ready = (r_state == S_IDLE) && !color_valid && !rst;
    busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_wait_len <= GAP_ONLY;
      r_pend_clr <= 1'b0;
      r_row      <= 5'd0;
      r_col      <= 7'd0;
      r_crow     <= 5'd0;
      r_ccol     <= 7'd0;
      r_wrow     <= 5'd0;
      r_wcol     <= 7'd0;
      r_wdata    <= 8'h00;
      r_instr    <= 16'h0000;
      r_iaddr    <= 16'h8000;
    end else begin
      r_cnt <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      if (r_state == S_IDLE && color_valid) begin
        r_instr    <= {(color_sel ? 8'h03 : 8'h02), color_value};
        r_iaddr    <= 16'h8000;
        r_wait_len <= GAP_ONLY;
        r_pend_clr <= 1'b0;
      end else if (w_accept_byte) begin
        if (w_printable) begin
          r_wrow     <= r_row;
          r_wcol     <= r_col;
          r_wdata    <= in_data;
          r_wait_len <= GAP_ONLY;
          if (r_col == COL_LAST) begin
            // Wrap: the row clear is queued behind the character write.
            r_col      <= 7'd0;
            r_row      <= w_row_inc;
            r_pend_clr <= 1'b1;
            r_instr    <= 16'h0500;
            r_iaddr    <= 16'h8000 | {3'b000, w_row_inc, 8'h00};
          end else begin
            r_col      <= r_col + 7'd1;
            r_pend_clr <= 1'b0;
          end
        end else begin
          case (in_data)
            8'h0D: begin
              r_col  <= 7'd0;
              r_ccol <= 7'd0;
            end
            8'h0A: begin
              r_col      <= 7'd0;
              r_row      <= w_row_inc;
              r_instr    <= 16'h0500;
              r_iaddr    <= 16'h8000 | {3'b000, w_row_inc, 8'h00};
              r_wait_len <= LINE_GAP;
              r_pend_clr <= 1'b0;
            end
            8'h08: if (r_col != 7'd0) begin
              r_col      <= r_col - 7'd1;
              r_wrow     <= r_row;
              r_wcol     <= r_col - 7'd1;
              r_wdata    <= 8'h20;
              r_wait_len <= GAP_ONLY;
              r_pend_clr <= 1'b0;
            end
            8'h0C: begin
              r_row      <= 5'd0;
              r_col      <= 7'd0;
              r_instr    <= 16'h0400;
              r_iaddr    <= 16'h8000;
              r_wait_len <= SCR_GAP;
              r_pend_clr <= 1'b0;
            end
            default: ;
          endcase
        end
      end
      if (r_state == S_WAIT && w_next == S_INSTR) begin
        r_pend_clr <= 1'b0;
        r_wait_len <= LINE_GAP;
      end
      if (r_state != S_IDLE && w_next == S_IDLE) begin
        r_crow <= r_row;
        r_ccol <= r_col;
      end
    end
  end

endmodule

// File: tb/tb_gpu_console_writer.sv
// Bench for gpu_console_writer: directed scenarios plus random byte streams, with bus
// actions captured by a monitor and scored against a cursor-level reference model.
module tb_gpu_console_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        color_valid = 1'b0;
  logic        color_sel = 1'b0;
  logic [7:0]  color_value = 8'h00;
  logic [15:0] cpu_write_address;
  logic [7:0]  cpu_write_data;
  logic [15:0] io_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int tests = 0;
  int fails = 0;

  gpu_console_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .color_valid(color_valid), .color_sel(color_sel), .color_value(color_value),
    .cpu_write_address(cpu_write_address), .cpu_write_data(cpu_write_data),
    .io_data(io_data), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: bus actions as {address, data, io}
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          len_q[$];
  int          m_row = 0;
  int          m_col = 0;

  task automatic model_newline();
    m_row = (m_row == 29) ? 0 : m_row + 1;
    exp_q.push_back({16'h8000 | 16'(m_row * 256), 8'h00, 16'h0500});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({16'(m_row * 128 + m_col), b, 16'h0000});
      m_col++;
      if (m_col == 80) begin
        m_col = 0;
        model_newline();
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_newline();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back({16'(m_row * 128 + m_col), 8'h20, 16'h0000});
      end
    end else if (b == 8'h0C) begin
      exp_q.push_back({16'h8000, 8'h00, 16'h0400});
      m_row = 0;
      m_col = 0;
    end
  endtask

  task automatic model_color(input logic sel, input logic [7:0] v);
    exp_q.push_back({16'h8000, 8'h00, (sel ? 8'h03 : 8'h02), v});
  endtask

  // monitor: collapse each strobe into one action plus its held length
  logic [39:0] mon_cur;
  logic [39:0] run_val;
  int          run_len = 0;
  bit          in_run = 1'b0;

  always @(negedge clk) begin
    mon_cur = {cpu_write_address, (cpu_write_address[15] ? 8'h00 : cpu_write_data), io_data};
    if (rst) in_run = 1'b0;
    else if (cpu_write_address != 16'h8000 || io_data != 16'h0000) begin
      if (in_run && mon_cur == run_val) run_len++;
      else begin
        if (in_run) begin obs_q.push_back(run_val); len_q.push_back(run_len); end
        run_val = mon_cur;
        run_len = 1;
        in_run  = 1'b1;
      end
    end else if (in_run) begin
      obs_q.push_back(run_val);
      len_q.push_back(run_len);
      in_run = 1'b0;
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 10000) begin @(negedge clk); t++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_byte(b);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < budget) begin @(negedge clk); t++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle timeout: busy=%0b required 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({cpu_write_address, cpu_write_data, io_data, busy, in_ready, cursor_row, cursor_col} !==
        {16'h8000, 8'h00, 16'h0000, 1'b0, 1'b0, 5'd0, 7'd0}) begin
      fails++;
      $display("FAIL reset_values: addr=%h data=%h io=%h busy=%b rdy=%b cur=(%0d,%0d) required 8000/00/0000/0/0/(0,0)",
               cpu_write_address, cpu_write_data, io_data, busy, in_ready, cursor_row, cursor_col);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_char_a();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h41;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL char_a_ready: in_ready=%b required 1", in_ready); end
    @(posedge clk);
    model_byte(8'h41);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 4) begin
        tests++;
        if ({cpu_write_address, cpu_write_data, busy} !== {16'h0000, 8'h41, 1'b1}) begin
          fails++;
          $display("FAIL char_a_strobe[%0d]: addr=%h data=%h busy=%b required 0000/41/1", k, cpu_write_address, cpu_write_data, busy);
        end
      end
      if (k == 1) begin
        tests++;
        if ({cursor_row, cursor_col} !== {5'd0, 7'd0}) begin
          fails++; $display("FAIL char_a_cursor_mid: cur=(%0d,%0d) required (0,0)", cursor_row, cursor_col);
        end
      end
      if (k == 5) begin
        tests++;
        if ({cpu_write_address, io_data, in_ready} !== {16'h8000, 16'h0000, 1'b0}) begin
          fails++; $display("FAIL char_a_gap: addr=%h io=%h rdy=%b required 8000/0000/0", cpu_write_address, io_data, in_ready);
        end
      end
      if (k == 6) begin
        tests++;
        if ({in_ready, cursor_row, cursor_col} !== {1'b1, 5'd0, 7'd1}) begin
          fails++; $display("FAIL char_a_done: rdy=%b cur=(%0d,%0d) required 1,(0,1)", in_ready, cursor_row, cursor_col);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    send_byte(8'h0D);
    for (int i = 0; i < 80; i++) send_byte(8'($urandom_range(32, 126)));
    wait_idle(1000);
    n = obs_q.size();
    tests++;
    if ({cursor_row, cursor_col} !== {5'd1, 7'd0}) begin
      fails++; $display("FAIL wrap_cursor: cur=(%0d,%0d) required (1,0)", cursor_row, cursor_col);
    end
    tests++;
    if (n < 2) begin fails++; $display("FAIL wrap_actions: count=%0d required >=2", n); end
    else begin
      if (obs_q[n-2][39:24] !== 16'h004F) begin
        fails++; $display("FAIL wrap_last_write: addr=%h required 004F", obs_q[n-2][39:24]);
      end
      tests++;
      if (obs_q[n-1] !== {16'h8100, 8'h00, 16'h0500}) begin
        fails++; $display("FAIL wrap_clear_line: action=%h required 8100000500", obs_q[n-1]);
      end
    end
  endtask

  task automatic test_row_wrap();
    int n;
    for (int i = 0; i < 28; i++) send_byte(8'h0A);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(32, 126)));
    wait_idle(500);
    tests++;
    if ({cursor_row, cursor_col} !== {5'd29, 7'd10}) begin
      fails++; $display("FAIL row_wrap_setup: cur=(%0d,%0d) required (29,10)", cursor_row, cursor_col);
    end
    send_byte(8'h0A);
    wait_idle(500);
    n = obs_q.size();
    tests++;
    if (n == 0 || obs_q[n-1] !== {16'h8000, 8'h00, 16'h0500}) begin
      fails++; $display("FAIL row_wrap_clear: action=%h required 8000000500", (n == 0) ? 40'h0 : obs_q[n-1]);
    end
    tests++;
    if ({cursor_row, cursor_col} !== {5'd0, 7'd0}) begin
      fails++; $display("FAIL row_wrap_cursor: cur=(%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_bs();
    int n;
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    wait_idle(500);
    n = obs_q.size();
    send_byte(8'h08);
    repeat (6) @(negedge clk);
    tests++;
    if ({obs_q.size() == n, busy, cursor_row, cursor_col} !== {1'b1, 1'b0, 5'd3, 7'd0}) begin
      fails++; $display("FAIL bs_col0: actions=%0d busy=%b cur=(%0d,%0d) required %0d,0,(3,0)", obs_q.size(), busy, cursor_row, cursor_col, n);
    end
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(32, 126)));
    send_byte(8'h08);
    wait_idle(100);
    n = obs_q.size();
    tests++;
    if (n == 0 || obs_q[n-1] !== {16'h0184, 8'h20, 16'h0000}) begin
      fails++; $display("FAIL bs_write: action=%h required 0184200000", (n == 0) ? 40'h0 : obs_q[n-1]);
    end
    tests++;
    if ({cursor_row, cursor_col} !== {5'd3, 7'd4}) begin
      fails++; $display("FAIL bs_cursor: cur=(%0d,%0d) required (3,4)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_color();
    int n;
    int t;
    n = obs_q.size();
    @(negedge clk);
    color_valid = 1'b1; color_sel = 1'b1; color_value = 8'h1C;
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL color_blocks_ready: in_ready=%b required 0", in_ready); end
    @(posedge clk);
    model_color(1'b1, 8'h1C);
    @(negedge clk);
    color_valid = 1'b0;
    tests++;
    if ({io_data, cpu_write_address} !== {16'h031C, 16'h8000}) begin
      fails++; $display("FAIL color_strobe: io=%h addr=%h required 031C/8000", io_data, cpu_write_address);
    end
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    tests++;
    if (!in_ready) begin fails++; $display("FAIL color_byte_deferred: in_ready=%b required 1", in_ready); in_valid = 1'b0; end
    else begin
      @(posedge clk);
      model_byte(8'h5A);
      @(negedge clk);
      in_valid = 1'b0;
    end
    wait_idle(100);
    tests++;
    if (obs_q.size() < n + 2 || obs_q[n] !== {16'h8000, 8'h00, 16'h031C} || obs_q[n+1][23:16] !== 8'h5A) begin
      fails++; $display("FAIL color_order: actions=%0d required color then byte 5A after index %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_random();
    int r;
    int t;
    logic [7:0] b;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 95) begin
        if (r < 70)      b = 8'($urandom_range(32, 126));
        else if (r < 78) b = 8'h0D;
        else if (r < 83) b = 8'h0A;
        else if (r < 91) b = 8'h08;
        else if (r < 93) b = 8'($urandom_range(128, 255));
        else             b = 8'($urandom_range(0, 1)) ? 8'h7F : 8'h1B;
        send_byte(b);
      end else begin
        t = 0;
        while (busy && t < 1000) begin @(negedge clk); t++; end
        color_valid = 1'b1;
        color_sel   = 1'($urandom_range(0, 1));
        color_value = 8'($urandom_range(0, 255));
        @(posedge clk);
        if (!busy) model_color(color_sel, color_value);
        @(negedge clk);
        color_valid = 1'b0;
      end
      if (i % 50 == 49) begin
        wait_idle(1000);
        tests++;
        if ({cursor_row, cursor_col} !== {5'(m_row), 7'(m_col)}) begin
          fails++; $display("FAIL random_cursor[%0d]: cur=(%0d,%0d) required (%0d,%0d)", i, cursor_row, cursor_col, m_row, m_col);
        end
      end
    end
  endtask

  task automatic test_ff();
    int cnt;
    send_byte(8'h51);
    wait_idle(100);
    send_byte(8'h0C);
    tests++;
    if (io_data !== 16'h0400 || cpu_write_address !== 16'h8000) begin
      fails++; $display("FAIL ff_instr: io=%h addr=%h required 0400/8000", io_data, cpu_write_address);
    end
    cnt = 0;
    while (busy && cnt < 6000) begin cnt++; @(negedge clk); end
    tests++;
    if (cnt !== 4101) begin fails++; $display("FAIL ff_busy_cycles: got %0d required 4101", cnt); end
    tests++;
    if ({cursor_row, cursor_col} !== {5'd0, 7'd0}) begin
      fails++; $display("FAIL ff_cursor: cur=(%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_scoreboard();
    wait_idle(1000);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL scoreboard_count: got %0d actions required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i] || len_q[i] !== 4) begin
        fails++; $display("FAIL scoreboard[%0d]: action=%h len=%0d required %h len=4", i, obs_q[i], len_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    send_byte(8'h52);
    send_byte(8'h0C);
    repeat (100) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rst_wait_setup: busy=%b required 1", busy); end
    rst = 1'b1;
    #1;
    tests++;
    if ({cpu_write_address, cpu_write_data, io_data, busy, in_ready, cursor_row, cursor_col} !==
        {16'h8000, 8'h00, 16'h0000, 1'b0, 1'b0, 5'd0, 7'd0}) begin
      fails++;
      $display("FAIL rst_mid_wait: addr=%h data=%h io=%h busy=%b rdy=%b cur=(%0d,%0d) required 8000/00/0000/0/0/(0,0)",
               cpu_write_address, cpu_write_data, io_data, busy, in_ready, cursor_row, cursor_col);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({in_ready, busy} !== {1'b1, 1'b0}) begin
      fails++; $display("FAIL rst_release: rdy=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_char_a();
    test_wrap();
    test_row_wrap();
    test_bs();
    test_color();
    test_random();
    test_ff();
    test_scoreboard();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
